rand_range_picker: RTL and testbench

RAND_RANGE_PICKER -- requirements
Module: rand_range_picker

---
 rtl/rand_pkg.sv | 19 +
 rtl/rand_range_picker.sv | 175 +++++++++++++++++
 tb/tb_rand_range_picker.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rand_pkg.sv
// Shared definitions for the bounded random value picker: FSM state
// encoding and default sizing.
package rand_pkg;

  // Controller states: waiting for a request, one-cycle seed load,
  // and repeated LFSR sampling with rejection.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEED   = 2'd1,
    ST_SAMPLE = 2'd2
  } state_e;

  // Width of LFSR data, seed, limit and returned value.
  localparam int DEFAULT_WIDTH = 11;

  // Number of rejected LFSR samples before giving up with a zero result.
  localparam int DEFAULT_MAX_TRIES = 16;

endpackage : rand_pkg

// File: rtl/rand_range_picker.sv
// Rejection-sampling front end for an external LFSR: returns a value in
// [0, limit) by drawing LFSR outputs until one falls below the limit,
// falling back to zero after MAX_TRIES rejects. The LFSR is seeded from
// a free-running cycle counter on the first request after reset or after
// a reseed pulse.
module rand_range_picker
  import rand_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int MAX_TRIES = DEFAULT_MAX_TRIES
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Req,
  input  logic [WIDTH-1:0] i_Limit,
  input  logic             i_Reseed,
  input  logic [WIDTH-1:0] i_LFSR_Data,
  output logic             o_LFSR_Enable,
  output logic             o_Seed_DV,
  output logic [WIDTH-1:0] o_Seed_Data,
  output logic [WIDTH-1:0] o_Value,
  output logic             o_Valid,
  output logic             o_Fallback,
  output logic             o_Err,
  output logic             o_Busy
);

  // Try counter must hold values up to MAX_TRIES-1.
  localparam int                TRY_W    = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]  LAST_TRY = TRY_W'(MAX_TRIES - 1);

  state_e             state_q,     state_d;
  logic               seeded_q,    seeded_d;
  logic               first_q,     first_d;
  logic [WIDTH-1:0]   cnt_q,       cnt_d;
  logic [TRY_W-1:0]   tries_q,     tries_d;
  logic [WIDTH-1:0]   limit_q,     limit_d;
  logic               enable_q,    enable_d;
  logic               seed_dv_q,   seed_dv_d;
  logic [WIDTH-1:0]   seed_data_q, seed_data_d;
  logic [WIDTH-1:0]   value_q,     value_d;
  logic               valid_q,     valid_d;
  logic               fallback_q,  fallback_d;
  logic               err_q,       err_d;
  logic               busy_q,      busy_d;

  // Next-state, counter and registered-output computation.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    seeded_d    = seeded_q;
    first_d     = 1'b0;
    cnt_d       = cnt_q + WIDTH'(1);
    tries_d     = tries_q;
    limit_d     = limit_q;
    enable_d    = 1'b0;
    seed_dv_d   = 1'b0;
    seed_data_d = seed_data_q;
    value_d     = value_q;
    valid_d     = 1'b0;
    fallback_d  = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_Req) begin
          if (i_Limit == '0) begin
            // Empty range: answer immediately with an error result.
            valid_d = 1'b1;
            err_d   = 1'b1;
            value_d = '0;
          end else begin
            limit_d = i_Limit;
            tries_d = '0;
            if (!seeded_q) begin
              // An all-zero seed would lock up the LFSR, so use 1 instead.
              state_d     = ST_SEED;
              seed_dv_d   = 1'b1;
              seed_data_d = (cnt_q == '0) ? WIDTH'(1) : cnt_q;
              seeded_d    = 1'b1;
            end else begin
              state_d  = ST_SAMPLE;
              enable_d = 1'b1;
              first_d  = 1'b1;
            end
          end
        end
      end

      ST_SEED: begin
        state_d  = ST_SAMPLE;
        enable_d = 1'b1;
        first_d  = 1'b1;
      end

      ST_SAMPLE: begin
        if (first_q) begin
          // The LFSR has not stepped past its pre-request value yet.
          enable_d = 1'b1;
        end else if (i_LFSR_Data < limit_q) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          value_d = i_LFSR_Data;
        end else if (tries_q == LAST_TRY) begin
          state_d    = ST_IDLE;
          valid_d    = 1'b1;
          fallback_d = 1'b1;
          value_d    = '0;
        end else begin
          tries_d  = tries_q + TRY_W'(1);
          enable_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A reseed request wins over the seeding of a request on the same edge.
    if (i_Reseed) begin
      seeded_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // values from before this edge, independent of statement order.
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      seeded_q    <= 1'b0;
      first_q     <= 1'b0;
      cnt_q       <= '0;
      tries_q     <= '0;
      limit_q     <= '0;
      enable_q    <= 1'b0;
      seed_dv_q   <= 1'b0;
      seed_data_q <= '0;
      value_q     <= '0;
      valid_q     <= 1'b0;
      fallback_q  <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seeded_q    <= seeded_d;
      first_q     <= first_d;
      cnt_q       <= cnt_d;
      tries_q     <= tries_d;
      limit_q     <= limit_d;
      enable_q    <= enable_d;
      seed_dv_q   <= seed_dv_d;
      seed_data_q <= seed_data_d;
      value_q     <= value_d;
      valid_q     <= valid_d;
      fallback_q  <= fallback_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign o_LFSR_Enable = enable_q;
  assign o_Seed_DV     = seed_dv_q;
  assign o_Seed_Data   = seed_data_q;
  assign o_Value       = value_q;
  assign o_Valid       = valid_q;
  assign o_Fallback    = fallback_q;
  assign o_Err         = err_q;
  assign o_Busy        = busy_q;

endmodule : rand_range_picker

// File: tb/tb_rand_range_picker.sv
// Self-checking bench for rand_range_picker. The LFSR is replaced by a
// scripted registered source; expected results and seed strobes are queued
// when requests are driven and compared when the DUT produces them.
module tb_rand_range_picker;

  localparam int W     = 11;
  localparam int TRIES = 16;

  logic         clk = 1'b0;
  logic         i_Rst, i_Req, i_Reseed;
  logic [W-1:0] i_Limit;
  logic [W-1:0] lfsr_data = W'(7);
  logic         o_LFSR_Enable, o_Seed_DV, o_Valid, o_Fallback, o_Err, o_Busy;
  logic [W-1:0] o_Seed_Data, o_Value;

  always #5 clk = ~clk;

  rand_range_picker #(.WIDTH(W), .MAX_TRIES(TRIES)) dut (
    .i_Clk         (clk),
    .i_Rst         (i_Rst),
    .i_Req         (i_Req),
    .i_Limit       (i_Limit),
    .i_Reseed      (i_Reseed),
    .i_LFSR_Data   (lfsr_data),
    .o_LFSR_Enable (o_LFSR_Enable),
    .o_Seed_DV     (o_Seed_DV),
    .o_Seed_Data   (o_Seed_Data),
    .o_Value       (o_Value),
    .o_Valid       (o_Valid),
    .o_Fallback    (o_Fallback),
    .o_Err         (o_Err),
    .o_Busy        (o_Busy)
  );

  typedef struct {
    logic [W-1:0] value;
    logic         fb;
    logic         err;
    int           start;
    int           due;
  } exp_t;

  typedef struct {
    logic [W-1:0] seed;
    int           due;
  } seed_t;

  exp_t         exp_q[$];
  seed_t        seed_q[$];
  int           script[$];
  logic [W-1:0] idle_fill = W'(7);

  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] cnt_model = '0;
  logic         model_seeded = 1'b0;
  logic [W-1:0] last_val = '0;
  int           en_cnt = 0;
  int           seed_cnt = 0;
  logic         prev_seed = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Edge count and reference model of the free-running cycle counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (i_Rst) cnt_model <= '0;
    else       cnt_model <= cnt_model + W'(1);
  end

  // LFSR stub: steps to the next scripted value on every enabled edge.
  always @(posedge clk) begin
    if (o_LFSR_Enable) begin
      if (script.size() > 0) lfsr_data <= W'(script.pop_front());
      else                   lfsr_data <= idle_fill;
    end
  end

  // Monitor: samples outputs 2 time units after each rising edge.
  always @(posedge clk) begin
    logic  exp_busy;
    exp_t  e;
    seed_t s;
    #2;
    if (i_Rst) begin
      check("rst_valid",     32'(o_Valid),       0);
      check("rst_value",     32'(o_Value),       0);
      check("rst_fallback",  32'(o_Fallback),    0);
      check("rst_err",       32'(o_Err),         0);
      check("rst_busy",      32'(o_Busy),        0);
      check("rst_enable",    32'(o_LFSR_Enable), 0);
      check("rst_seed_dv",   32'(o_Seed_DV),     0);
      check("rst_seed_data", 32'(o_Seed_Data),   0);
      last_val  = '0;
      prev_seed = 1'b0;
    end else begin
      check("enable_seed_excl", 32'(o_LFSR_Enable & o_Seed_DV), 0);
      check("qualifier_no_valid", 32'((o_Fallback | o_Err) & ~o_Valid), 0);
      if (prev_seed) check("enable_after_seed", 32'(o_LFSR_Enable), 1);
      prev_seed = o_Seed_DV;
      en_cnt   += int'(o_LFSR_Enable);
      seed_cnt += int'(o_Seed_DV);

      exp_busy = 1'b0;
      if (!o_Valid && exp_q.size() > 0 && !exp_q[0].err && cyc >= exp_q[0].start)
        exp_busy = 1'b1;
      check("busy", 32'(o_Busy), 32'(exp_busy));

      if (o_Seed_DV) begin
        if (seed_q.size() == 0) begin
          check("unexpected_seed", 1, 0);
        end else begin
          s = seed_q.pop_front();
          check("seed_data",  32'(o_Seed_Data), 32'(s.seed));
          check("seed_cycle", 32'(cyc),         32'(s.due));
        end
      end

      if (o_Valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("value",       32'(o_Value),    32'(e.value));
          check("fallback",    32'(o_Fallback), 32'(e.fb));
          check("err",         32'(o_Err),      32'(e.err));
          check("valid_cycle", 32'(cyc),        32'(e.due));
          last_val = e.value;
        end
      end else begin
        check("value_hold", 32'(o_Value), 32'(last_val));
      end
    end
  end

  // Drive one request (call at a falling edge) and queue its expectations.
  // ncmp is the number of compares the request needs to finish.
  task automatic issue(input logic [W-1:0] limit, input int ncmp,
                       input logic [W-1:0] val, input logic fb);
    exp_t  e;
    seed_t s;
    e.start = cyc + 1;
    e.err   = (limit == '0);
    e.fb    = (limit != '0) && fb;
    e.value = (limit == '0) ? '0 : val;
    if (limit == '0) begin
      e.due = e.start;
    end else begin
      e.due = e.start + 1 + ncmp;
      if (!model_seeded) begin
        s.seed = (cnt_model == '0) ? W'(1) : cnt_model;
        s.due  = e.start;
        seed_q.push_back(s);
        e.due++;
        model_seeded = 1'b1;
      end
    end
    exp_q.push_back(e);
    i_Req   = 1'b1;
    i_Limit = limit;
    @(negedge clk);
    i_Req   = 1'b0;
    i_Limit = W'($urandom);
  endtask

  // Wait (bounded) until every queued result has been seen.
  task automatic wait_idle(input string tag);
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_pending"}, 32'(exp_q.size()), 0);
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    int e0, s0;
    i_Rst = 1'b1; i_Req = 1'b0; i_Limit = '0; i_Reseed = 1'b0;
    repeat (2) @(negedge clk);
    i_Rst = 1'b0;
    repeat (5) @(negedge clk);

    // Test 1: first request seeds from the counter (5 cycles after reset).
    script.push_back(100);
    issue(W'(640), 1, W'(100), 1'b0);
    wait_idle("t1");

    // Test 2: one reject then accept.
    script.push_back(700); script.push_back(300);
    issue(W'(640), 2, W'(300), 1'b0);
    wait_idle("t2");

    // Boundary: limit itself is rejected, limit-1 accepted.
    script.push_back(640); script.push_back(639);
    issue(W'(640), 2, W'(639), 1'b0);
    wait_idle("t2b");

    // Boundary: limit 1 only accepts 0.
    script.push_back(1); script.push_back(0);
    issue(W'(1), 2, W'(0), 1'b0);
    wait_idle("t2c");

    // Test 3: every sample rejected -> fallback.
    for (int i = 0; i < TRIES; i++) script.push_back(2000);
    issue(W'(640), TRIES, W'(0), 1'b1);
    wait_idle("t3");

    // Test 4: zero limit while seeded, no LFSR or seed activity.
    e0 = en_cnt; s0 = seed_cnt;
    issue(W'(0), 0, W'(0), 1'b0);
    wait_idle("t4");
    check("t4_enable_activity", 32'(en_cnt - e0), 0);
    check("t4_seed_activity",   32'(seed_cnt - s0), 0);

    // Test 5: reset on the 3rd SAMPLE cycle aborts the request.
    for (int i = 0; i < 6; i++) script.push_back(2000);
    issue(W'(640), 6, W'(0), 1'b0);
    @(negedge clk);
    @(negedge clk);
    i_Rst = 1'b1;
    exp_q.delete();
    model_seeded = 1'b0;
    @(negedge clk);
    i_Rst = 1'b0;
    script.delete();
    repeat (4) @(negedge clk);

    // Zero limit while unseeded must not seed.
    e0 = en_cnt; s0 = seed_cnt;
    issue(W'(0), 0, W'(0), 1'b0);
    wait_idle("t5_err");
    check("t5_enable_activity", 32'(en_cnt - e0), 0);
    check("t5_seed_activity",   32'(seed_cnt - s0), 0);

    // Next real request reseeds.
    script.push_back(222);
    issue(W'(640), 1, W'(222), 1'b0);
    wait_idle("t5_reseed");

    // Test 6: reseed between requests, dropped request and reseed while busy.
    script.push_back(50);
    issue(W'(640), 1, W'(50), 1'b0);
    wait_idle("t6a");
    i_Reseed = 1'b1;
    @(negedge clk);
    i_Reseed = 1'b0;
    model_seeded = 1'b0;
    script.push_back(2000); script.push_back(2000);
    script.push_back(2000); script.push_back(123);
    issue(W'(640), 4, W'(123), 1'b0);
    i_Req = 1'b1; i_Limit = '0;
    @(negedge clk);
    i_Req = 1'b0;
    i_Reseed = 1'b1;
    @(negedge clk);
    i_Reseed = 1'b0;
    model_seeded = 1'b0;
    wait_idle("t6b");

    // Widest limit after the mid-operation reseed: seeds again.
    script.push_back(2046);
    issue(W'(2047), 1, W'(2046), 1'b0);
    wait_idle("t6c");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule : tb_rand_range_picker
